// File: rtl/ft245_pkg.sv
// Shared timing constants, state encoding and ns-to-cycles helper for the FT245 bridge.
package ft245_pkg;

    localparam int RD_ACTIVE_NS    = 50;
    localparam int RD_PRECHARGE_NS = 130;
    localparam int WR_SETUP_NS     = 20;
    localparam int WR_ACTIVE_NS    = 50;
    localparam int WR_PRECHARGE_NS = 50;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACTIVE,
        RD_PRECHARGE,
        WR_SETUP,
        WR_ACTIVE,
        WR_PRECHARGE
    } state_t;

    function automatic int ns_to_cycles(input int ns, input int period_ns);
        int cycles;
        cycles = (ns + period_ns - 1) / period_ns;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/ft245_block_sync2.sv
// Two-flop synchronizer; resets to 1 so the inactive-high FT245 flags read as "not ready".
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ft245_block.sv
// FT245 asynchronous FIFO bridge: arbitrates rx/tx, times RD#/WR strobes with a single
// down-counter and presents simple valid/ack interfaces on both sides.
module ft245_block
    import ft245_pkg::*;
#(
    parameter int FT245_WIDTH     = 8,
    parameter int CLOCK_PERIOD_NS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire  [FT245_WIDTH-1:0] in_out_245,
    input  logic                   rxf_245,
    output logic                   rx_245,
    input  logic                   txe_245,
    output logic                   wr_245,
    output logic [FT245_WIDTH-1:0] rx_data_si,
    output logic                   rx_rdy_si,
    input  logic                   rx_ack_si,
    input  logic [FT245_WIDTH-1:0] tx_data_si,
    input  logic                   tx_rdy_si,
    output logic                   tx_ack_si
);

    localparam int RD_ACT_CYC = ns_to_cycles(RD_ACTIVE_NS, CLOCK_PERIOD_NS);
    localparam int RD_PRE_CYC = ns_to_cycles(RD_PRECHARGE_NS, CLOCK_PERIOD_NS);
    localparam int WR_SET_CYC = ns_to_cycles(WR_SETUP_NS, CLOCK_PERIOD_NS);
    localparam int WR_ACT_CYC = ns_to_cycles(WR_ACTIVE_NS, CLOCK_PERIOD_NS);
    localparam int WR_PRE_CYC = ns_to_cycles(WR_PRECHARGE_NS, CLOCK_PERIOD_NS);

    localparam int MAX_A   = (RD_ACT_CYC > RD_PRE_CYC) ? RD_ACT_CYC : RD_PRE_CYC;
    localparam int MAX_B   = (WR_SET_CYC > WR_ACT_CYC) ? WR_SET_CYC : WR_ACT_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > WR_PRE_CYC) ? MAX_AB : WR_PRE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Counter holds "cycles remaining minus one"; the write precharge load is one larger
    // because its first cycle is the data hold cycle.
    localparam logic [CNT_W-1:0] RD_ACT_LD  = CNT_W'(RD_ACT_CYC - 1);
    localparam logic [CNT_W-1:0] RD_PRE_LD  = CNT_W'(RD_PRE_CYC - 1);
    localparam logic [CNT_W-1:0] WR_SET_LD  = CNT_W'(WR_SET_CYC - 1);
    localparam logic [CNT_W-1:0] WR_ACT_LD  = CNT_W'(WR_ACT_CYC - 1);
    localparam logic [CNT_W-1:0] WR_HOLD_LD = CNT_W'(WR_PRE_CYC);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   last_tx, last_tx_n;
    logic                   capture;
    logic                   rxf_sync, txe_sync;
    logic                   rx_ok, tx_ok;
    logic                   bus_en;
    logic [FT245_WIDTH-1:0] tx_hold;

    sync2 u_sync_rxf (.clk(clk), .rst(rst), .d(rxf_245), .q(rxf_sync));
    sync2 u_sync_txe (.clk(clk), .rst(rst), .d(txe_245), .q(txe_sync));

    assign rx_ok = !rxf_sync && !rx_rdy_si;
    assign tx_ok = tx_rdy_si && !txe_sync;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_tx_n = last_tx;
        capture   = 1'b0;
        tx_ack_si = 1'b0;
        if (cnt != '0)
            cnt_n = cnt - 1'b1;
        case (state)
            IDLE: begin
                // Round-robin: on a tie the direction not served last goes first.
                if (rx_ok && (!tx_ok || last_tx)) begin
                    state_n   = RD_ACTIVE;
                    cnt_n     = RD_ACT_LD;
                    last_tx_n = 1'b0;
                end else if (tx_ok) begin
                    state_n   = WR_SETUP;
                    cnt_n     = WR_SET_LD;
                    last_tx_n = 1'b1;
                    tx_ack_si = 1'b1;
                end
            end
            RD_ACTIVE: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = RD_PRECHARGE;
                    cnt_n   = RD_PRE_LD;
                end
            end
            RD_PRECHARGE: if (cnt == '0) state_n = IDLE;
            WR_SETUP: begin
                if (cnt == '0) begin
                    state_n = WR_ACTIVE;
                    cnt_n   = WR_ACT_LD;
                end
            end
            WR_ACTIVE: begin
                if (cnt == '0) begin
                    state_n = WR_PRECHARGE;
                    cnt_n   = WR_HOLD_LD;
                end
            end
            WR_PRECHARGE: if (cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_tx    <= 1'b1;
            rx_rdy_si  <= 1'b0;
            rx_data_si <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            last_tx <= last_tx_n;
            if (capture) begin
                rx_data_si <= in_out_245;
                rx_rdy_si  <= 1'b1;
            end else if (rx_ack_si) begin
                rx_rdy_si  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_ack_si)
            tx_hold <= tx_data_si;
    end

    assign rx_245     = (state != RD_ACTIVE);
    assign wr_245     = (state == WR_ACTIVE);
    assign bus_en     = (state == WR_SETUP) || (state == WR_ACTIVE) ||
                        ((state == WR_PRECHARGE) && (cnt == WR_HOLD_LD));
    assign in_out_245 = bus_en ? tx_hold : {FT245_WIDTH{1'bz}};

endmodule

// File: tb/tb_ft245_block.sv
// Directed bench for ft245_block: models the FT245 side and checks strobe timing,
// handshakes, arbitration and asynchronous reset.
module tb_ft245_block;

    logic       clk = 1'b0;
    logic       rst;
    wire  [7:0] bus;
    logic       rxf, txe, rx_245, wr_245;
    logic [7:0] rx_data, tx_data, ft_data;
    logic       rx_rdy, rx_ack, tx_rdy, tx_ack;

    int   errors = 0;
    int   checks = 0;
    int   n, m, ev_cnt, kind, exp_kind;
    logic prev_rd, ack_pending;

    always #5 clk = ~clk;

    // FT245 drives its data only while RD# is low; otherwise the bus floats to 0.
    assign bus = rx_245 ? 8'bzzzz_zzzz : ft_data;
    for (genvar i = 0; i < 8; i++) begin : g_pd
        pulldown (bus[i]);
    end

    ft245_block #(.FT245_WIDTH(8), .CLOCK_PERIOD_NS(10)) dut (
        .clk(clk), .rst(rst), .in_out_245(bus),
        .rxf_245(rxf), .rx_245(rx_245), .txe_245(txe), .wr_245(wr_245),
        .rx_data_si(rx_data), .rx_rdy_si(rx_rdy), .rx_ack_si(rx_ack),
        .tx_data_si(tx_data), .tx_rdy_si(tx_rdy), .tx_ack_si(tx_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rxf = 1'b1; txe = 1'b1; rx_ack = 1'b0;
        tx_data = 8'h00; tx_rdy = 1'b0; ft_data = 8'h00;
        tick(3);
        check("rst_rd", rx_245, 1);
        check("rst_wr", wr_245, 0);
        check("rst_bus", bus, 8'h00);
        check("rst_rx_rdy", rx_rdy, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_tx_ack", tx_ack, 0);

        // First read: 2 sync cycles plus one IDLE decision cycle before RD# falls.
        rst = 1'b0; rxf = 1'b0; ft_data = 8'hA5;
        n = 0; while (rx_245 && n < 20) begin tick(1); n++; end
        check("rd1_latency", n, 3);
        n = 0; while (!rx_245 && n < 30) begin n++; tick(1); end
        check("rd1_low_cycles", n, 5);
        check("rd1_rdy", rx_rdy, 1);
        check("rd1_data", rx_data, 8'hA5);

        // Holding register full: no new read while unacknowledged.
        ft_data = 8'h5A;
        n = 0; repeat (40) begin tick(1); if (!rx_245) n++; end
        check("no_rd_while_full", n, 0);
        check("rd1_rdy_held", rx_rdy, 1);
        check("rd1_data_held", rx_data, 8'hA5);
        rx_ack = 1'b1; tick(1); rx_ack = 1'b0;
        check("rx_rdy_clear", rx_rdy, 0);
        n = 0; while (rx_245 && n < 20) begin tick(1); n++; end
        check("rd2_latency", n, 1);
        n = 0; while (!rx_245 && n < 30) begin n++; tick(1); end
        check("rd2_low_cycles", n, 5);
        check("rd2_data", rx_data, 8'h5A);

        // Immediate ack: RD# high = 13 precharge + 1 IDLE cycle.
        rx_ack = 1'b1; ft_data = 8'h11;
        n = 0; while (rx_245 && n < 40) begin n++; tick(1); rx_ack = 1'b0; end
        check("rd_high_cycles", n, 14);
        rxf = 1'b1;
        n = 0; while (!rx_rdy && n < 20) begin tick(1); n++; end
        check("rd3_data", rx_data, 8'h11);
        rx_ack = 1'b1; tick(1); rx_ack = 1'b0;
        tick(15);

        // Write of 0x3C.
        tx_data = 8'h3C; tx_rdy = 1'b1; txe = 1'b0;
        n = 0; while (!tx_ack && n < 20) begin tick(1); n++; end
        check("tx_ack_latency", n, 2);
        tick(1);
        check("tx_ack_width", tx_ack, 0);
        tx_data = 8'hFF; tx_rdy = 1'b0;
        n = 0; while (!wr_245 && n < 20) begin if (bus === 8'h3C) n++; tick(1); end
        check("wr_setup_cycles", n, 2);
        n = 0; m = 0;
        while (wr_245 && n < 20) begin n++; if (bus !== 8'h3C) m++; tick(1); end
        check("wr_high_cycles", n, 5);
        check("bus_during_wr", m, 0);
        check("bus_hold", bus, 8'h3C);
        tick(1);
        check("bus_release", bus, 8'h00);

        // TXE# high blocks the write until it falls.
        tick(10);
        txe = 1'b1; tick(3);
        tx_data = 8'h96; tx_rdy = 1'b1;
        n = 0; m = 0;
        repeat (10) begin tick(1); if (tx_ack) n++; if (wr_245) m++; end
        check("txe_block_ack", n, 0);
        check("txe_block_wr", m, 0);
        txe = 1'b0;
        n = 0; while (!tx_ack && n < 20) begin tick(1); n++; end
        check("txe_fall_ack", n, 2);
        tick(1); tx_rdy = 1'b0;
        n = 0; while (!wr_245 && n < 20) begin n++; tick(1); end
        check("txe_wr_rise", n, 2);
        check("txe_wr_bus", bus, 8'h96);
        tick(20);

        // Both directions eligible: rx first (tx served last), then alternating.
        rxf = 1'b0; ft_data = 8'h81;
        tick(2);
        tx_data = 8'h40; tx_rdy = 1'b1;
        prev_rd = rx_245; ack_pending = 1'b0; ev_cnt = 0;
        for (int c = 0; c < 400 && ev_cnt < 6; c++) begin
            tick(1);
            rx_ack = rx_rdy;
            if (ack_pending) begin tx_data = tx_data + 8'h01; ack_pending = 1'b0; end
            kind = -1;
            if (prev_rd && !rx_245) kind = 0;
            if (tx_ack) begin kind = 1; ack_pending = 1'b1; end
            if (kind >= 0) begin
                exp_kind = ev_cnt % 2;
                check("alternate_order", kind, exp_kind);
                ev_cnt++;
            end
            if (!rx_245) check("bus_while_rd", bus, ft_data);
            check("rd_wr_exclusive", {31'b0, (!rx_245 && wr_245)}, 0);
            prev_rd = rx_245;
        end
        check("alternate_events", ev_cnt, 6);
        tick(1);
        rxf = 1'b1; tx_rdy = 1'b0;
        repeat (40) begin tick(1); rx_ack = rx_rdy; end
        rx_ack = 1'b0;

        // Reset during WR_ACTIVE.
        tx_data = 8'hC3; tx_rdy = 1'b1;
        n = 0; while (!tx_ack && n < 20) begin tick(1); n++; end
        tick(1); tx_rdy = 1'b0;
        n = 0; while (!wr_245 && n < 20) begin tick(1); n++; end
        check("pre_rst_wr_high", wr_245, 1);
        tick(2);
        rst = 1'b1; #1;
        check("rst_mid_wr", wr_245, 0);
        check("rst_mid_bus", bus, 8'h00);
        check("rst_mid_rd", rx_245, 1);
        check("rst_mid_rx_rdy", rx_rdy, 0);
        check("rst_mid_rx_data", rx_data, 8'h00);
        check("rst_mid_tx_ack", tx_ack, 0);
        tick(1); rst = 1'b0;
        n = 0; repeat (20) begin tick(1); if (wr_245 || !rx_245 || tx_ack) n++; end
        check("post_rst_quiet", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
